// File: rtl/rm_event_dispatcher.sv
// Runtime-monitor event dispatcher: compacts commit-side events into a FIFO and
// hands them one per cycle, round-robin over enabled lanes, via valid/ready.
module rm_event_dispatcher #(
  parameter int unsigned NrLanes   = 8,
  parameter int unsigned NrEvents  = 32,
  parameter int unsigned NrIns     = 2,
  parameter int unsigned DataW     = 64,
  parameter int unsigned FifoDepth = 8,
  localparam int unsigned IdW      = $clog2(NrEvents)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic [NrIns-1:0]         ev_valid_i,
  input  logic [NrIns*IdW-1:0]     ev_id_i,
  input  logic [NrIns*DataW-1:0]   ev_data_i,
  output logic                     ev_ready_o,
  input  logic [NrLanes-1:0]       lane_en_i,
  output logic [NrLanes-1:0]       lane_valid_o,
  output logic [IdW-1:0]           lane_id_o,
  output logic [DataW-1:0]         lane_data_o,
  input  logic [NrLanes-1:0]       lane_ready_i,
  output logic [31:0]              drop_cnt_o,
  output logic                     busy_o
);

  localparam int unsigned PtrW  = $clog2(FifoDepth);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned LaneW = $clog2(NrLanes);

  logic [IdW-1:0]     fifo_id   [FifoDepth];
  logic [DataW-1:0]   fifo_data [FifoDepth];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    count_q, free_slots, n_wr, n_drop;
  logic [NrIns-1:0]   wr_en;
  logic [PtrW-1:0]    wr_addr [NrIns];

  logic [LaneW-1:0]   rr_q, sel_lane, cand;
  logic               sel_found;
  logic               stage_valid, accept, load;
  logic [NrLanes-1:0] lane_valid_q;
  logic [IdW-1:0]     lane_id_q;
  logic [DataW-1:0]   lane_data_q;

  logic [31:0]        drop_cnt_q, drop_cnt_d;
  logic [32:0]        drop_sum;

  // Room is judged on the registered count, so a same-edge pop never helps the enqueue.
  assign free_slots = CntW'(FifoDepth) - count_q;

  always_comb begin
    n_wr   = '0;
    n_drop = '0;
    for (int i = 0; i < NrIns; i++) begin
      wr_en[i]   = 1'b0;
      wr_addr[i] = '0;
      if (ev_valid_i[i] && !flush_i) begin
        if (n_wr < free_slots) begin
          wr_en[i]   = 1'b1;
          wr_addr[i] = wr_ptr_q + n_wr[PtrW-1:0];
          // NOTE: blocking assignments here build a running tally across ports;
          // combinational blocks use '=' and sequential blocks use '<='.
          n_wr       = n_wr + CntW'(1);
        end else begin
          n_drop = n_drop + CntW'(1);
        end
      end
    end
  end

  assign drop_sum   = {1'b0, drop_cnt_q} + 33'(n_drop);
  assign drop_cnt_d = drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];

  // First enabled lane at or after rr_q, wrapping through the natural overflow of LaneW bits.
  always_comb begin
    sel_found = 1'b0;
    sel_lane  = '0;
    cand      = '0;
    for (int off = 0; off < NrLanes; off++) begin
      cand = rr_q + LaneW'(off);
      if (!sel_found && lane_en_i[cand]) begin
        sel_found = 1'b1;
        sel_lane  = cand;
      end
    end
  end

  assign stage_valid = |lane_valid_q;
  assign accept      = |(lane_valid_q & lane_ready_i);
  assign load        = (count_q != '0) && (!stage_valid || accept) && sel_found;

  // NOTE: storage arrays carry no reset; the count and pointers alone say which entries are live.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NrIns; i++) begin
      if (wr_en[i]) begin
        fifo_id[wr_addr[i]]   <= ev_id_i[i*IdW +: IdW];
        fifo_data[wr_addr[i]] <= ev_data_i[i*DataW +: DataW];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rr_q         <= '0;
      lane_valid_q <= '0;
      lane_id_q    <= '0;
      lane_data_q  <= '0;
      drop_cnt_q   <= '0;
    end else if (flush_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      lane_valid_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_q + n_wr[PtrW-1:0];
      rd_ptr_q   <= rd_ptr_q + PtrW'(load);
      count_q    <= count_q + n_wr - CntW'(load);
      drop_cnt_q <= drop_cnt_d;
      if (load) begin
        lane_valid_q <= NrLanes'(1) << sel_lane;
        lane_id_q    <= fifo_id[rd_ptr_q];
        lane_data_q  <= fifo_data[rd_ptr_q];
        rr_q         <= sel_lane + LaneW'(1);
      end else if (accept) begin
        lane_valid_q <= '0;
      end
    end
  end

  assign ev_ready_o   = free_slots >= CntW'(NrIns);
  assign busy_o       = (count_q != '0) || stage_valid;
  assign lane_valid_o = lane_valid_q;
  assign lane_id_o    = lane_id_q;
  assign lane_data_o  = lane_data_q;
  assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_rm_event_dispatcher.sv
// Self-checking bench for rm_event_dispatcher: directed vector table, hand-written
// corner sequences, and randomized traffic against a queue-based reference model.
module tb_rm_event_dispatcher;

  localparam int NL = 8;
  localparam int IW = 5;
  localparam int NI = 2;
  localparam int DW = 64;
  localparam int FD = 8;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             flush_i;
  logic [NI-1:0]    ev_valid_i;
  logic [NI*IW-1:0] ev_id_i;
  logic [NI*DW-1:0] ev_data_i;
  logic             ev_ready_o;
  logic [NL-1:0]    lane_en_i;
  logic [NL-1:0]    lane_valid_o;
  logic [IW-1:0]    lane_id_o;
  logic [DW-1:0]    lane_data_o;
  logic [NL-1:0]    lane_ready_i;
  logic [31:0]      drop_cnt_o;
  logic             busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  rm_event_dispatcher #(
    .NrLanes(NL), .NrEvents(32), .NrIns(NI), .DataW(DW), .FifoDepth(FD)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .ev_valid_i(ev_valid_i), .ev_id_i(ev_id_i), .ev_data_i(ev_data_i),
    .ev_ready_o(ev_ready_o), .lane_en_i(lane_en_i),
    .lane_valid_o(lane_valid_o), .lane_id_o(lane_id_o), .lane_data_o(lane_data_o),
    .lane_ready_i(lane_ready_i), .drop_cnt_o(drop_cnt_o), .busy_o(busy_o)
  );

  // Reference model: a queue of pending events plus one output slot.
  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } ev_t;

  ev_t    q[$];
  bit     m_valid;
  int     m_lane;
  ev_t    m_ev;
  int     m_rr;
  longint m_drop;

  typedef struct {
    logic [1:0] v;
    int         id0;
    int         id1;
    logic [7:0] exp_valid;
    int         exp_id;
    logic       exp_busy;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] dat(input int id);
    logic [DW-1:0] d;
    d = 64'hD000 + 64'(id);
    return d;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    ev_valid_i = '0;
    ev_id_i    = '0;
    ev_data_i  = '0;
    flush_i    = 1'b0;
  endtask

  task automatic put(input logic [1:0] v, input int id0, input int id1);
    ev_valid_i = v;
    ev_id_i    = {IW'(id1), IW'(id0)};
    ev_data_i  = {dat(id1), dat(id0)};
  endtask

  task automatic model_reset();
    q.delete();
    m_valid = 1'b0;
    m_lane  = 0;
    m_rr    = 0;
    m_drop  = 0;
  endtask

  task automatic do_reset();
    rst_ni       = 1'b0;
    idle();
    lane_en_i    = '1;
    lane_ready_i = '1;
    step();
    check("rst_lane_valid", 64'(lane_valid_o), 64'h0);
    check("rst_ev_ready",   64'(ev_ready_o),   64'h1);
    check("rst_busy",       64'(busy_o),       64'h0);
    check("rst_drop",       64'(drop_cnt_o),   64'h0);
    rst_ni = 1'b1;
    model_reset();
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic model_edge();
    if (flush_i) begin
      q.delete();
      m_valid = 1'b0;
    end else begin
      int free;
      bit acc;
      bit ld;
      free = FD - q.size();
      acc  = m_valid && lane_ready_i[m_lane];
      ld   = (q.size() > 0) && (!m_valid || acc) && (lane_en_i != '0);
      if (acc) m_valid = 1'b0;
      if (ld) begin
        for (int o = 0; o < NL; o++) begin
          int c;
          c = (m_rr + o) % NL;
          if (lane_en_i[c]) begin
            m_lane = c;
            break;
          end
        end
        m_ev    = q.pop_front();
        m_valid = 1'b1;
        m_rr    = (m_lane + 1) % NL;
      end
      for (int i = 0; i < NI; i++) begin
        if (ev_valid_i[i]) begin
          if (free > 0) begin
            ev_t e;
            e.id   = ev_id_i[i*IW +: IW];
            e.data = ev_data_i[i*DW +: DW];
            q.push_back(e);
            free--;
          end else if (m_drop < 64'hFFFF_FFFF) begin
            m_drop++;
          end
        end
      end
    end
  endtask

  initial begin
    // Round-robin table: row i drives cycle i and checks the outputs of cycle i+1.
    tbl[0] = '{2'b11, 0, 1, 8'h00, 0, 1'b1};
    tbl[1] = '{2'b11, 2, 3, 8'h01, 0, 1'b1};
    tbl[2] = '{2'b11, 4, 5, 8'h02, 1, 1'b1};
    tbl[3] = '{2'b11, 6, 7, 8'h04, 2, 1'b1};
    tbl[4] = '{2'b00, 0, 0, 8'h08, 3, 1'b1};
    tbl[5] = '{2'b00, 0, 0, 8'h10, 4, 1'b1};
    tbl[6] = '{2'b00, 0, 0, 8'h20, 5, 1'b1};
    tbl[7] = '{2'b00, 0, 0, 8'h40, 6, 1'b1};
    tbl[8] = '{2'b00, 0, 0, 8'h80, 7, 1'b1};
    tbl[9] = '{2'b00, 0, 0, 8'h00, 0, 1'b0};

    // Single event, single lane.
    do_reset();
    ev_valid_i = 2'b01;
    ev_id_i    = {IW'(0), IW'(5)};
    ev_data_i  = {64'h0, 64'hDEAD};
    step();
    idle();
    check("single_c1_valid", 64'(lane_valid_o), 64'h0);
    step();
    check("single_c2_valid", 64'(lane_valid_o), 64'h01);
    check("single_c2_id",    64'(lane_id_o),    64'd5);
    check("single_c2_data",  lane_data_o,       64'hDEAD);
    step();
    check("single_c3_busy",  64'(busy_o),       64'h0);

    // Round-robin and ordering from the table.
    do_reset();
    for (int r = 0; r < 10; r++) begin
      put(tbl[r].v, tbl[r].id0, tbl[r].id1);
      step();
      check($sformatf("rr%0d_valid", r), 64'(lane_valid_o), 64'(tbl[r].exp_valid));
      if (tbl[r].exp_valid != '0) begin
        check($sformatf("rr%0d_id", r),   64'(lane_id_o), 64'(tbl[r].exp_id));
        check($sformatf("rr%0d_data", r), lane_data_o,    dat(tbl[r].exp_id));
      end
      check($sformatf("rr%0d_busy", r), 64'(busy_o), 64'(tbl[r].exp_busy));
    end
    check("rr_drop", 64'(drop_cnt_o), 64'h0);

    // Overflow with every lane disabled.
    do_reset();
    lane_en_i    = '0;
    lane_ready_i = '0;
    for (int c = 0; c < 5; c++) begin
      put(2'b11, 2*c, 2*c+1);
      step();
      check($sformatf("ovf%0d_ev_ready", c), 64'(ev_ready_o), (c < 3) ? 64'h1 : 64'h0);
      check($sformatf("ovf%0d_valid", c),    64'(lane_valid_o), 64'h0);
    end
    idle();
    check("ovf_drop", 64'(drop_cnt_o), 64'd2);
    check("ovf_busy", 64'(busy_o),     64'h1);
    lane_en_i    = '1;
    lane_ready_i = '1;
    for (int e = 0; e < 8; e++) begin
      step();
      check($sformatf("ovf_drain%0d_valid", e), 64'(lane_valid_o), 64'(1) << e);
      check($sformatf("ovf_drain%0d_id", e),    64'(lane_id_o),    64'(e));
    end
    step();
    check("ovf_drained_busy", 64'(busy_o), 64'h0);

    // Mask and stability.
    do_reset();
    lane_en_i    = 8'h24;
    lane_ready_i = '0;
    put(2'b11, 10, 11);
    step();
    idle();
    step();
    check("mask_first_valid", 64'(lane_valid_o), 64'h04);
    check("mask_first_id",    64'(lane_id_o),    64'd10);
    lane_ready_i = 8'h04;
    step();
    check("mask_second_valid", 64'(lane_valid_o), 64'h20);
    check("mask_second_id",    64'(lane_id_o),    64'd11);
    lane_ready_i = 8'hDF;
    lane_en_i    = 8'h04;
    for (int h = 0; h < 3; h++) begin
      step();
      check($sformatf("mask_hold%0d_valid", h), 64'(lane_valid_o), 64'h20);
      check($sformatf("mask_hold%0d_id", h),    64'(lane_id_o),    64'd11);
      check($sformatf("mask_hold%0d_data", h),  lane_data_o,       dat(11));
    end
    lane_ready_i = 8'h20;
    step();
    check("mask_release_valid", 64'(lane_valid_o), 64'h0);
    check("mask_release_busy",  64'(busy_o),       64'h0);

    // Flush during back-pressure: stage loaded, six events queued.
    do_reset();
    lane_ready_i = '0;
    put(2'b11, 0, 1); step();
    put(2'b11, 2, 3); step();
    put(2'b11, 4, 5); step();
    put(2'b01, 6, 0); step();
    idle();
    check("flush_pre_valid",    64'(lane_valid_o), 64'h01);
    check("flush_pre_ev_ready", 64'(ev_ready_o),   64'h1);
    begin
      logic [31:0] pre_drop;
      pre_drop = drop_cnt_o;
      flush_i  = 1'b1;
      put(2'b11, 20, 21);
      step();
      idle();
      check("flush_valid",    64'(lane_valid_o), 64'h0);
      check("flush_busy",     64'(busy_o),       64'h0);
      check("flush_drop",     64'(drop_cnt_o),   64'(pre_drop));
      check("flush_ev_ready", 64'(ev_ready_o),   64'h1);
    end
    step();
    check("flush_after_busy", 64'(busy_o), 64'h0);
    lane_ready_i = '1;
    put(2'b01, 9, 0);
    step();
    idle();
    step();
    check("flush_rr_kept_valid", 64'(lane_valid_o), 64'h02);
    check("flush_rr_kept_id",    64'(lane_id_o),    64'd9);

    // Reset mid-handshake.
    do_reset();
    lane_en_i    = '0;
    lane_ready_i = '0;
    for (int c = 0; c < 5; c++) begin
      put(2'b11, 2*c, 2*c+1);
      step();
    end
    idle();
    check("rstmid_pre_drop", 64'(drop_cnt_o), 64'd2);
    lane_en_i = 8'h08;
    step();
    check("rstmid_pre_valid", 64'(lane_valid_o), 64'h08);
    rst_ni = 1'b0;
    #1;
    check("rstmid_valid",    64'(lane_valid_o), 64'h0);
    check("rstmid_ev_ready", 64'(ev_ready_o),   64'h1);
    check("rstmid_drop",     64'(drop_cnt_o),   64'h0);
    check("rstmid_busy",     64'(busy_o),       64'h0);
    step();
    rst_ni    = 1'b1;
    lane_en_i = '1;
    put(2'b01, 3, 0);
    step();
    idle();
    step();
    check("rstmid_after_valid", 64'(lane_valid_o), 64'h01);
    check("rstmid_after_id",    64'(lane_id_o),    64'd3);

    // Randomized traffic against the reference model.
    do_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      ev_valid_i   = NI'($urandom);
      ev_id_i      = (NI*IW)'($urandom);
      ev_data_i    = {$urandom, $urandom, $urandom, $urandom};
      lane_en_i    = ($urandom_range(0, 7) == 0) ? '0 : NL'($urandom);
      lane_ready_i = ($urandom_range(0, 3) == 0) ? '0 : NL'($urandom);
      flush_i      = ($urandom_range(0, 39) == 0);
      model_edge();
      step();
      check("rand_valid", 64'(lane_valid_o), m_valid ? (64'(1) << m_lane) : 64'h0);
      if (m_valid) begin
        check("rand_id",   64'(lane_id_o), 64'(m_ev.id));
        check("rand_data", lane_data_o,    m_ev.data);
      end
      check("rand_ev_ready", 64'(ev_ready_o), 64'((FD - q.size()) >= NI));
      check("rand_busy",     64'(busy_o),     64'((q.size() > 0) || m_valid));
      check("rand_drop",     64'(drop_cnt_o), 64'(m_drop));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rm_event_dispatcher.md
# rm_event_dispatcher

Transmit side of the runtime-monitor (RM) event path. It accepts up to `NrIns` retired-instruction events per cycle from commit, buffers them in a FIFO, and hands them one per cycle, round-robin, to the `NrLanes` rule-checking lanes over a valid/ready handshake. It never stalls commit: events that do not fit are dropped and counted.

## Interface
Parameters:
- `NrLanes`, 8: number of rule-checking lanes; power of 2.
- `NrEvents`, 32: event-id space; `IdW = $clog2(NrEvents)` = 5.
- `NrIns`, 2: events offered per cycle; equals the number of commit ports.
- `DataW`, 64: event payload width (XLEN).
- `FifoDepth`, 8: FIFO entries; power of 2, at least `NrIns`.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `flush_i`  in  1  synchronous clear of FIFO and output stage.
- `ev_valid_i`  in  `NrIns`  per-port event valid.
- `ev_id_i`  in  `NrIns`x`IdW`  per-port event id.
- `ev_data_i`  in  `NrIns`x`DataW`  per-port payload.
- `ev_ready_o`  out  1  FIFO free slots >= `NrIns`; informative only, not a stall.
- `lane_en_i`  in  `NrLanes`  lane enable mask.
- `lane_valid_o`  out  `NrLanes`  one-hot (or zero) target-lane valid.
- `lane_id_o`  out  `IdW`  shared event id bus.
- `lane_data_o`  out  `DataW`  shared payload bus.
- `lane_ready_i`  in  `NrLanes`  per-lane ready.
- `drop_cnt_o`  out  32  saturating count of dropped events.
- `busy_o`  out  1  FIFO non-empty or output stage loaded.

## Operation
- **Enqueue.**
  - Valid ports are compacted in port order, port 0 first, and written to consecutive FIFO slots at the clock edge.
  - Let k = number of valid ports and f = free slots. `min(k,f)` lowest-index valid events are written; the remaining `k-f` events are dropped.
  - `drop_cnt_o` increases by `k-f` and saturates at 0xFFFF_FFFF.
- **Output stage.** A single register holds {id, data, target lane} plus a valid bit.
  - It loads from the FIFO head when all three hold: the FIFO is non-empty, the stage is empty or its event is being accepted this cycle, and `lane_en_i` is not all-zero.
  - A load pops the FIFO in the same edge.
- **Lane select.**
  - At load, the target is the first enabled lane at index >= `rr_q`, wrapping modulo `NrLanes`.
  - `rr_q` is then set to target+1, wrapping.
  - The target stays fixed until accepted, even if its `lane_en_i` bit drops.
- **Handshake.**
  - `lane_valid_o[t]` = stage valid and target == t.
  - Transfer happens when `lane_valid_o[t] & lane_ready_i[t]`.
  - While valid, the id, data and target hold stable.
  - `lane_ready_i` of non-target lanes is ignored.
- **All lanes disabled.** No loads occur; the FIFO fills and further events are dropped and counted.
- **Simultaneous enqueue and pop.** Free slots for the enqueue are computed from the registered count, before the pop. A pop in the same cycle does not create room for that cycle's inputs.
- **Flush.**
  - Empties the FIFO and the output stage at the edge, and discards the same-cycle inputs without counting them.
  - `rr_q` and `drop_cnt_o` are kept.
  - Flush takes priority over enqueue, load and transfer.
- **Reset.** Asynchronous, at any time, including mid-handshake.
  - FIFO pointers and count, stage valid, `rr_q` and `drop_cnt_o` go to 0.
  - `lane_id_o` and `lane_data_o` go to 0.
  - Resulting outputs: `lane_valid_o`=0, `ev_ready_o`=1, `busy_o`=0.

## Timing
- `ev_ready_o` and `busy_o` are decoded from registered state only, with no input-to-output path.
- `lane_valid_o` is registered.
- Latency: an event presented in cycle 0 is written to the FIFO at edge 1, loaded into the output stage at edge 2, and shows `lane_valid_o` in cycle 2. Minimum latency is 2 cycles.
- Throughput: with the target ready every cycle, one event is dispatched per cycle. An accept and the next load happen in the same edge, with no bubble.
- The FIFO count is `$clog2(FifoDepth)+1` bits wide; pointers wrap modulo `FifoDepth`.

## Test plan
- **Single event, single lane.** Reset; all lanes enabled and ready; one event id=5, data=0xDEAD on port 0 in cycle 0. Required: `lane_valid_o`=0x01 in cycle 2 with id 5 and data 0xDEAD; `busy_o`=0 in cycle 3.
- **Round-robin and ordering.** Both ports valid for 4 cycles with ids 0..7, all lanes ready. Required: ids emitted in order 0..7 to lanes 0,1,...,7, one per cycle; `drop_cnt_o`=0.
- **Overflow.** `lane_ready_i`=0; both ports valid for 5 cycles. Required: 8 events stored; `ev_ready_o` falls once fewer than 2 slots are free; `drop_cnt_o`=2; stored ids are the first 8 in port order.
- **Mask and stability.** `lane_en_i`=0x24 with `rr_q`=0. Required: the first event goes to lane 2 and the next to lane 5. While lane 5 holds `lane_ready_i`=0 and its enable is cleared, the outputs stay stable until ready is given.
- **Flush during back-pressure.** FIFO holding 6 events with the stage valid; assert `flush_i` with both ports valid in the same cycle. Required: next cycle `lane_valid_o`=0, `busy_o`=0, `drop_cnt_o` unchanged.
- **Reset mid-handshake.** Assert `rst_ni` low while `lane_valid_o`=0x08. Required: immediately `lane_valid_o`=0, `ev_ready_o`=1, `drop_cnt_o`=0; after release, the first event goes to lane 0.
